// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
//   Reads words from a synchronous FIFO read port (one-cycle read latency)
//   and presents them as a valid/ready stream grouped into PKT_LEN-word
//   packets. A 3-entry skid queue absorbs the read latency, so the stream
//   runs at one word per cycle when the FIFO and the consumer keep up.
//
// Ports
//   rclk, rrst_n    read-domain clock, asynchronous active-low reset
//   empty           FIFO empty flag (registered inside the FIFO)
//   data_out        FIFO read data, valid the cycle after an accepted read
//   r_en            FIFO read request; accepted at an edge with r_en & !empty
//   flush           synchronous discard of buffered and in-flight words
//   m_valid/m_ready output handshake
//   m_data, m_last  oldest buffered word, final-word-of-packet marker
//   buf_cnt         number of words held in the queue (0..3)
//
// Handshake: a word transfers at a rising edge where m_valid=1 and m_ready=1.
// Once m_valid rises, m_data/m_last hold until that transfer (or a flush or
// reset). m_valid never depends on m_ready, and r_en never depends on m_ready.
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            buf_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            count;
  logic                  pend;      // a read was accepted last edge; data_out is live
  logic [7:0]            beat_cnt;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue a read only if the queue still has room once the in-flight word
  // lands; this is what keeps the 3-entry queue from ever overflowing.
  assign r_en    = !empty && !flush && (({1'b0, count} + {2'b00, pend}) <= 3'd2);
  assign push    = pend && !flush;
  assign pop     = m_valid && m_ready;

  assign m_valid = (count != 2'd0);
  assign m_data  = mem[head];
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);
  assign buf_cnt = count;

  // Storage has no reset: nothing is readable while count is 0.
  always_ff @(posedge rclk) begin
    if (push) begin
      mem[tail] <= data_out;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 2'd0;
      pend     <= 1'b0;
      beat_cnt <= 8'd0;
    end else if (flush) begin
      // Clearing pend here is what drops the word returning next cycle.
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 2'd0;
      pend     <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      pend <= r_en;
      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head     <= ptr_inc(head);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

  localparam int DW      = 8;
  localparam int PKT_LEN = 4;

  // ---------------- clock / reset ----------------
  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          empty;
  logic [DW-1:0] data_out;
  logic          r_en;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    buf_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .empty   (empty),
    .data_out(data_out),
    .r_en    (r_en),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .buf_cnt (buf_cnt)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] fifo_q[$];   // contents of the modelled FIFO
  logic [DW-1:0] exp_q[$];    // words the stream must still deliver, in order
  int rd_total  = 0;          // reads accepted by the FIFO model
  int pop_total = 0;          // words delivered on the stream
  int exp_beat  = 0;
  int lasts_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (registered empty, 1-cycle read latency) ----
  initial begin : fifo_model
    logic acc;
    data_out = '0;
    empty    = 1'b1;
    forever begin
      @(posedge rclk);
      acc = r_en && !empty;   // pre-edge values
      #1;
      if (acc) begin
        data_out = fifo_q.pop_front();
        rd_total++;
      end
      empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge rclk) begin
    if (rrst_n) begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word at %0t", m_data, $time);
        end else begin
          chk("data", m_data, exp_q.pop_front());
          chk("last", m_last, (exp_beat == PKT_LEN - 1) ? 1 : 0);
          if (m_last) lasts_seen++;
          exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
          pop_total++;
        end
      end
    end
    prev_stall = rrst_n && m_valid && !m_ready && !flush;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) load_word(DW'($urandom_range(0, 255)));
  endtask

  // Words read from the FIFO but not delivered are gone after flush/reset.
  task automatic drop_inflight();
    int n;
    n = rd_total - pop_total;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    pop_total = rd_total;
    exp_beat  = 0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drop_inflight();
  endtask

  task automatic drain(input string name, input int budget, input logic [7:0] pat);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && c < budget) begin
      m_ready = pat[c % 8];
      step();
      c++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_bufcnt(input string name, input logic [1:0] target);
    int c;
    c = 0;
    while (buf_cnt != target && c < 20) begin
      step();
      c++;
    end
    chk(name, buf_cnt, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         n_words;
    logic [7:0] ready_pat;
    int         exp_lasts;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] a_words [4];
    logic [1:0]    a_valid [7];

    vecs[0] = '{4,  8'hFF, 1};
    vecs[1] = '{8,  8'hAA, 2};
    vecs[2] = '{7,  8'hCC, 1};
    vecs[3] = '{12, 8'h6D, 3};
    vecs[4] = '{1,  8'hFF, 0};
    vecs[5] = '{5,  8'h01, 1};

    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_buf_cnt", buf_cnt, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_r_en", r_en, 0);
    rrst_n = 1'b1;
    step();

    // Four words, consumer always ready: first word two cycles after r_en.
    a_words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    a_valid = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};  // {valid,last}
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) load_word(a_words[i]);
    step();
    chk("lat_r_en_c0", r_en, 1);
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("lat_valid_c%0d", c), m_valid, a_valid[c][1]);
      chk($sformatf("lat_last_c%0d", c), m_last, a_valid[c][0]);
      if (c >= 2 && c <= 5) chk($sformatf("lat_data_c%0d", c), m_data, a_words[c-2]);
      step();
    end

    // Six words with the consumer stalled: the queue fills to exactly three.
    m_ready = 1'b0;
    load(6);
    repeat (8) step();
    chk("stall_buf_cnt", buf_cnt, 3);
    chk("stall_r_en", r_en, 0);
    chk("stall_reads", fifo_q.size(), 3);
    drain("stall", 64, 8'hFF);

    // Table-driven streams with varied backpressure.
    foreach (vecs[k]) begin
      flush_pulse();
      lasts_seen = 0;
      load(vecs[k].n_words);
      drain($sformatf("vec%0d", k), 200, vecs[k].ready_pat);
      chk($sformatf("vec%0d_lasts", k), lasts_seen, vecs[k].exp_lasts);
      chk($sformatf("vec%0d_idle", k), buf_cnt, 0);
    end

    // Flush with two words buffered and one in flight.
    flush_pulse();
    m_ready = 1'b0;
    load(7);
    wait_bufcnt("flush_setup", 2'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_buf_cnt", buf_cnt, 0);
    chk("flush_m_valid", m_valid, 0);
    chk("flush_reads", fifo_q.size(), 4);
    drop_inflight();
    lasts_seen = 0;
    drain("flush", 64, 8'hFF);
    chk("flush_lasts", lasts_seen, 1);

    // Asynchronous reset with a full queue.
    m_ready = 1'b0;
    load(6);
    wait_bufcnt("rst_setup", 2'd3);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_buf_cnt", buf_cnt, 0);
    chk("arst_m_last", m_last, 0);
    step();
    step();
    rrst_n = 1'b1;
    drop_inflight();
    lasts_seen = 0;
    load(4);
    drain("arst", 64, 8'hFF);
    chk("arst_lasts", lasts_seen, 1);

    // FIFO runs dry mid-packet, then refills.
    flush_pulse();
    m_ready = 1'b1;
    load(2);
    drain("dry", 32, 8'hFF);
    chk("dry_m_valid", m_valid, 0);
    chk("dry_r_en", r_en, 0);
    load(2);
    begin
      int c;
      c = 0;
      while (!m_valid && c < 10) begin
        step();
        c++;
      end
    end
    chk("refill_valid", m_valid, 1);
    chk("refill_w3_last", m_last, 0);
    step();
    chk("refill_w4_valid", m_valid, 1);
    chk("refill_w4_last", m_last, 1);
    drain("refill", 32, 8'hFF);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_streamer.md
FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of the FIFO read port and output stream.
REQ-002 Parameter PKT_LEN, default 4, words per output packet (legal 1..255).
REQ-003 rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-004 rrst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 empty  input  1  FIFO empty flag, registered in the FIFO on rclk.
REQ-006 data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
REQ-007 r_en  output  1  FIFO read request; a read is accepted at an edge where r_en=1 and empty=0.
REQ-008 flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-009 m_valid  output  1  output word available.
REQ-010 m_ready  input  1  downstream accepts the word at an edge where m_valid=1 and m_ready=1 (pop).
REQ-011 m_data  output  DATA_WIDTH  output word, oldest buffered entry.
REQ-012 m_last  output  1  marks the final word of a PKT_LEN-word packet.
REQ-013 buf_cnt  output  2  number of words held in the output buffer (0..3).

Function
REQ-014 Buffer shall be a 3-entry in-order queue: head pointer, tail pointer, count.
REQ-015 Register pend shall be set at an edge with an accepted read, else cleared.
REQ-016 At any edge with pend=1, data_out shall be pushed at the tail.
REQ-017 r_en = !empty & !flush & ((count + pend) <= 2).
REQ-018 r_en shall depend only on registered state, empty and flush, never on m_ready.
REQ-019 Buffer shall never overflow; a push when count=3 is a design error.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-021 Head and tail pointers shall wrap 2 -> 0.
REQ-022 m_valid = (count != 0); m_data = entry at head.
REQ-023 m_data and m_last shall hold stable while m_valid=1 and m_ready=0.
REQ-024 Sustained throughput with empty=0 and m_ready=1: one word per cycle after a 2-cycle fill latency.
REQ-025 Counter beat_cnt (8 bits) shall increment on each pop and wrap to 0 after PKT_LEN-1.
REQ-026 m_last = m_valid & (beat_cnt == PKT_LEN-1).
REQ-027 Empty FIFO: r_en=0; buffered words continue to drain; m_valid deasserts when count reaches 0.
REQ-028 flush=1 at an edge shall clear count, head, tail, pend and beat_cnt.
REQ-029 The word arriving the cycle after flush shall be discarded: no push occurs when pend was cleared by flush.
REQ-030 flush shall take priority over push and pop in the same cycle; a pop in that cycle is not counted.
REQ-031 buf_cnt = count.

Reset
REQ-032 While rrst_n=0: count=0, head=0, tail=0, pend=0, beat_cnt=0.
REQ-033 Consequently m_valid=0, m_last=0, buf_cnt=0; r_en follows REQ-017.
REQ-034 Reset asserted mid-transfer: all buffered and in-flight words are lost; no push after release.
REQ-035 First accepted read may occur at the first rclk edge after rrst_n rises.

Verification
REQ-036 FIFO holds A1,A2,A3,A4; m_ready=1 -> r_en high from cycle 0; m_data A1..A4 on consecutive cycles starting cycle 2; m_last only with A4 (PKT_LEN=4).
REQ-037 FIFO holds 6 words; m_ready=0 -> exactly 3 reads accepted, buf_cnt=3, r_en=0; then m_ready=1 -> remaining 3 words delivered in order, none lost or duplicated.
REQ-038 m_ready toggles 1010... over 8 words with PKT_LEN=3 -> order preserved; m_last on words 3 and 6; m_data stable while stalled.
REQ-039 buf_cnt=2 with a read in flight; pulse flush -> next cycle buf_cnt=0, m_valid=0; in-flight word absent; next FIFO word becomes beat 0 of a new packet.
REQ-040 Assert rrst_n=0 with buf_cnt=3 and pend=1 -> m_valid=0, buf_cnt=0 immediately, without waiting for an rclk edge; after release the stream restarts at beat 0.
REQ-041 FIFO empties mid-packet after word 2 -> m_valid falls after word 2 drains; refill -> word 3 delivered with beat_cnt=2 and m_last=0 (PKT_LEN=4).
